// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage. Holds the program counter, issues instruction-memory
// requests over a req/gnt/rvalid handshake and hands {pc, instr} pairs to
// decode through a 2-entry registered buffer with valid/ready flow control.
// After a redirect, responses still owed for the wrong path are dropped.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   redirect_valid load redirect_pc this cycle, flush the output buffer
//   redirect_pc    next-PC from the PC select mux (low two bits ignored)
//   imem_req       fetch request
//   imem_addr      fetch address (current PC, word aligned)
//   imem_gnt       request accepted (meaningful only while imem_req=1)
//   imem_rvalid    in-order response valid, at least one cycle after grant
//   imem_rdata     fetched instruction
//   if_valid       buffer head valid towards decode
//   if_ready       decode accepts the head this cycle
//   if_pc          PC of the head instruction (0 when if_valid=0)
//   if_instr       head instruction (0 when if_valid=0)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_instr
);

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);

  // Control state
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [1:0]            out_q, out_d;       // requests granted, response owed
  logic [1:0]            drop_q, drop_d;     // owed responses that are wrong-path
  logic                  aq_wr_q, aq_wr_d;
  logic                  aq_rd_q, aq_rd_d;
  logic                  f_wr_q, f_wr_d;
  logic                  f_rd_q, f_rd_d;
  logic [1:0]            f_cnt_q, f_cnt_d;

  // Data storage (not reset)
  logic [DATA_WIDTH-1:0] aq_q      [2];      // addresses of in-flight fetches
  logic [DATA_WIDTH-1:0] f_pc_q    [2];
  logic [DATA_WIDTH-1:0] f_instr_q [2];

  logic pop;
  logic grant;
  logic resp;
  logic push;
  logic pop_f;
  logic [2:0] inuse;

  assign imem_addr = pc_q & ALIGN_MASK;

  assign if_valid = rst_n & (f_cnt_q != 2'd0);
  assign if_pc    = {DATA_WIDTH{if_valid}} & f_pc_q[f_rd_q];
  assign if_instr = {DATA_WIDTH{if_valid}} & f_instr_q[f_rd_q];

  assign pop = if_valid & if_ready;

  // Credit: every granted request must already own a buffer slot, counting
  // the slot freed by this cycle's pop, so responses never need back-pressure.
  assign inuse    = {1'b0, out_q} + {1'b0, f_cnt_q};
  assign imem_req = rst_n & ~redirect_valid & (inuse < (3'd2 + {2'b00, pop}));

  assign grant = imem_req & imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp  = rst_n & imem_rvalid & (out_q != 2'd0);
  // Responses are kept only when on the correct path and not in a redirect cycle.
  assign push  = resp & (drop_q == 2'd0) & ~redirect_valid;
  // The flush on redirect overrides any pop.
  assign pop_f = pop & ~redirect_valid;

  always_comb begin
    pc_d    = pc_q;
    out_d   = out_q + 2'(grant) - 2'(resp);
    drop_d  = drop_q;
    aq_wr_d = aq_wr_q ^ grant;
    aq_rd_d = aq_rd_q ^ resp;
    f_wr_d  = f_wr_q ^ push;
    f_rd_d  = f_rd_q ^ pop_f;
    f_cnt_d = f_cnt_q + 2'(push) - 2'(pop_f);

    if (grant) begin
      pc_d = pc_q + PC_STEP;
    end
    if (resp && (drop_q != 2'd0)) begin
      drop_d = drop_q - 2'd1;
    end

    if (redirect_valid) begin
      pc_d    = redirect_pc & ALIGN_MASK;
      // No grant can happen this cycle, so everything still owed after this
      // cycle's response belongs to the abandoned path.
      drop_d  = out_q - 2'(resp);
      f_wr_d  = 1'b0;
      f_rd_d  = 1'b0;
      f_cnt_d = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC & ALIGN_MASK;
      out_q   <= 2'd0;
      drop_q  <= 2'd0;
      aq_wr_q <= 1'b0;
      aq_rd_q <= 1'b0;
      f_wr_q  <= 1'b0;
      f_rd_q  <= 1'b0;
      f_cnt_q <= 2'd0;
    end else begin
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      aq_wr_q <= aq_wr_d;
      aq_rd_q <= aq_rd_d;
      f_wr_q  <= f_wr_d;
      f_rd_q  <= f_rd_d;
      f_cnt_q <= f_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      aq_q[aq_wr_q] <= imem_addr;
    end
    if (push) begin
      f_pc_q[f_wr_q]    <= aq_q[aq_rd_q];
      f_instr_q[f_wr_q] <= imem_rdata;
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the RISC-V core. Holds the program counter, issues instruction-memory requests over a request/grant/response handshake, and presents fetched {pc, instr} pairs to decode through a 2-entry buffer with valid/ready flow control. It consumes the output of the next-PC select mux (`redirect_valid`/`redirect_pc`) and feeds the decode stage. In-flight fetches on the wrong path are discarded after a redirect.

## Interface
- `DATA_WIDTH`, 32: PC, address and instruction width.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset: one clock, reset is synchronous and active-low.
- `redirect_valid`  in  1  branch/jump taken; load `redirect_pc` this cycle.
- `redirect_pc`  in  DATA_WIDTH  selected next-PC from the PC mux.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  DATA_WIDTH  fetch address (current PC).
- `imem_gnt`  in  1  request accepted this cycle (counts only when `imem_req`=1).
- `imem_rvalid`  in  1  response valid; responses in order, at least 1 cycle after grant.
- `imem_rdata`  in  DATA_WIDTH  fetched instruction.
- `if_valid`  out  1  buffer head valid to decode.
- `if_ready`  in  1  decode accepts head this cycle.
- `if_pc`  out  DATA_WIDTH  PC of head instruction.
- `if_instr`  out  DATA_WIDTH  head instruction.

## Operation
- State: `pc`, in-flight address queue (2 entries), `outstanding` (0..2), `drop_cnt` (0..2), output FIFO (2 entries of {pc, instr}).
- Issue credit: `imem_req` = `rst_n` & ~`redirect_valid` & (`outstanding` + `fifo_count` − `pop` < 2), where `pop` = `if_valid` & `if_ready`. Every granted response is therefore guaranteed a FIFO slot; no response is ever lost or stalled.
- `imem_addr` = `pc`, with bits [1:0] always 0.
- Grant (`imem_req` & `imem_gnt`): push `pc` into the in-flight queue, `pc` <= `pc` + 4 (mod 2^DATA_WIDTH, wraps silently), `outstanding` += 1.
- Response (`imem_rvalid`): `outstanding` −= 1, pop the in-flight queue. If `drop_cnt` > 0, discard and decrement `drop_cnt`. Otherwise push {queued pc, `imem_rdata`} into the FIFO.
- `imem_rvalid` with `outstanding`=0 is a protocol error. It is ignored and counters are unchanged.
- Redirect (`redirect_valid`=1):
  - `pc` <= {`redirect_pc`[DATA_WIDTH-1:2], 2'b00}.
  - FIFO flushed, so `if_valid`=0 the next cycle.
  - `drop_cnt` <= `outstanding` after this cycle's response, so every wrong-path response still owed is dropped.
  - No request is issued in the redirect cycle.
  - A response arriving in the redirect cycle is discarded.
- Simultaneous grant, response and pop in one cycle are all honoured.
- Redirect overrides grant/pop bookkeeping for the FIFO. The flush wins.

## Timing
- Reset (`rst_n`=0 at edge):
  - `pc`=RESET_PC; `outstanding`, `drop_cnt` and FIFO count = 0.
  - `imem_req`=0 and `if_valid`=0 while `rst_n`=0.
  - `if_pc` and `if_instr` read 0.
- Reset mid-operation: all state is cleared regardless of outstanding requests. The memory side is reset by the same `rst_n`.
- First `imem_req`=1 occurs in the first cycle with `rst_n`=1.
- Latency: grant in cycle N, `imem_rvalid` in N+1, `if_valid`=1 in N+2 (FIFO is registered; outputs come from the FIFO head, with no combinational path from `imem_rdata`).
- Throughput: one instruction per cycle sustained with 1-cycle memory and `if_ready`=1.
- Redirect in cycle R: `imem_req`=0 in R, `imem_addr`=redirect target in R+1. The first new-path instruction reaches `if_valid` no earlier than R+3.
- Handshake: `if_pc`/`if_instr` stay stable while `if_valid`=1 and `if_ready`=0.

## Test plan
- Reset release, RESET_PC=0, 1-cycle memory returning addr as data, `if_ready`=1 -> addresses 0,4,8,… issued every cycle; `if_valid` from cycle 2; `if_instr`==`if_pc` each cycle.
- `if_ready`=0 for 5 cycles -> FIFO fills to 2; `imem_req` drops to 0 with `outstanding`+`fifo_count`=2; head holds pc=0. Releasing `if_ready` resumes in order with no gaps or duplicates.
- Memory latency 3 cycles with random `imem_gnt` -> PC sequence strictly +4 per grant; at most 2 outstanding; output order matches grant order.
- Redirect to 32'h0000_0100 with 2 outstanding -> both responses dropped; next `if_pc`=0x100, then 0x104.
- Redirect to 32'h0000_0203 coincident with `imem_rvalid` -> that response discarded; next fetch address 0x200.
- `rst_n`=0 for one cycle mid-stream with 2 outstanding -> `if_valid`=0 next cycle; fetch restarts at RESET_PC.
